// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared types for the core's data-memory port
package core_types_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        mem_size_t   size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    // Encoding 3 is not a legal member but behaves as a word access.
    function automatic logic [3:0] size_ben(input mem_size_t size);
        case (size)
            MEM_BYTE: size_ben = 4'b0001;
            MEM_HALF: size_ben = 4'b0011;
            default:  size_ben = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input mem_size_t size);
        case (size)
            MEM_BYTE: size_mask = 32'h0000_00ff;
            MEM_HALF: size_mask = 32'h0000_ffff;
            default:  size_mask = 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// rtl/dmem_lane_steer.sv - byte-lane steering for sub-word loads and stores
module dmem_lane_steer
    import core_types_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata,
    output logic        misaligned
);

    // Shifting within a 4-bit/32-bit field drops lanes past byte 3 for misaligned accesses.
    assign byte_en    = size_ben(size) << offset;
    assign lane_wdata = wdata << {offset, 3'b000};
    assign rdata      = (rword >> {offset, 3'b000}) & size_mask(size);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            MEM_BYTE: misaligned = 1'b0;
            MEM_HALF: misaligned = offset[0];
            default:  misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated handshaked data memory for the core MEM stage
// Optional: DMEM_MISALIGN_ERR_EN turns misaligned accesses into error responses.
module dmem_responder
    import core_types_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    mem_size_t     size_q, size_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          in_idle;
    mem_size_t     st_size;
    logic [AW+1:0] st_addr;
    logic          st_we;
    logic [31:0]   st_rword;
    logic [3:0]    byte_en;
    logic [31:0]   lane_wdata;
    logic [31:0]   steer_rdata;
    logic          misaligned;
    logic          wr_en;

    assign in_idle = (state_q == DM_IDLE);
    assign accept  = in_idle && req_ready_q && req_valid;

    // In IDLE the steering sees the live request (store commit, zero-wait loads);
    // afterwards it sees the latched request so the response can be built on RESP entry.
    assign st_size  = in_idle ? mem_size_t'(req_size) : size_q;
    assign st_addr  = in_idle ? req_addr[AW+1:0] : addr_q;
    assign st_we    = in_idle ? req_we : we_q;
    assign st_rword = mem[st_addr[AW+1:2]];

    dmem_lane_steer u_steer (
        .size       (st_size),
        .offset     (st_addr[1:0]),
        .wdata      (req_wdata),
        .rword      (st_rword),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .rdata      (steer_rdata),
        .misaligned (misaligned)
    );

`ifdef DMEM_MISALIGN_ERR_EN
    assign wr_en = accept && req_we && !misaligned;
`else
    assign wr_en = accept && req_we;
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            DM_IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    size_d = mem_size_t'(req_size);
                    addr_d = req_addr[AW+1:0];
                    if (WAIT_CYCLES > 0) begin
                        state_d = DM_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = DM_RESP;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q == 4'd0) state_d = DM_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DM_RESP: begin
                if (rsp_ready) state_d = DM_IDLE;
            end
            default: state_d = DM_IDLE;
        endcase

        if (state_d == DM_RESP && state_q != DM_RESP) begin
            rsp_rdata_d = st_we ? 32'd0 : steer_rdata;
            rsp_err_d   = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
            if (misaligned) begin
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b1;
            end
`endif
        end

        req_ready_d = (state_d == DM_IDLE);
        rsp_valid_d = (state_d == DM_RESP);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= DM_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= MEM_BYTE;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array contents survive reset, so a committed store is never lost.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[req_addr[AW+1:2]][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issue one request (req_ready assumed high), wait for the response, then accept it.
    task automatic xact(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        logic [31:0] rd;
        logic        er;
        xact(we, size, addr, wdata, lat, rd, er);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int seen_valid;

        nReset    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;

        step();
        step();
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        nReset = 1'b1;
        step();
        check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        op("st_word_10", 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op("ld_word_10", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        op("st_byte_13", 1'b1, 2'd0, 32'h13, 32'h0000_00AA, 32'h0, 1'b0);
        op("ld_word_10b", 1'b0, 2'd2, 32'h10, 32'h0, 32'hAAAD_BEEF, 1'b0);
        op("ld_half_12", 1'b0, 2'd1, 32'h12, 32'h0, 32'h0000_AAAD, 1'b0);
        op("ld_byte_11", 1'b0, 2'd0, 32'h11, 32'h0, 32'h0000_00BE, 1'b0);
        op("ld_size3_10", 1'b0, 2'd3, 32'h10, 32'h0, 32'hAAAD_BEEF, 1'b0);

        // Backpressure, with a stray store presented that must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        step();
        req_we    = 1'b1;
        req_wdata = 32'h0;
        seen_valid = 0;
        for (int i = 0; i < 40 && seen_valid == 0; i++) begin
            if (rsp_valid === 1'b1) seen_valid = 1;
            else step();
        end
        check("bp_valid_rose", 32'(seen_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata_held", rsp_rdata, 32'hAAAD_BEEF);
            check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_ready_after", {31'd0, req_ready}, 32'd1);
        op("bp_stray_store_ignored", 1'b0, 2'd2, 32'h10, 32'h0, 32'hAAAD_BEEF, 1'b0);

        op("st_wrap", 1'b1, 2'd2, 32'd4096 + 32'h4, 32'h0000_1234, 32'h0, 1'b0);
        op("ld_wrap", 1'b0, 2'd2, 32'h4, 32'h0, 32'h0000_1234, 1'b0);

        op("st_word_20", 1'b1, 2'd2, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
        op("st_misaligned_21", 1'b1, 2'd2, 32'h21, 32'hCAFE_F00D, 32'h0, 1'b1);
        op("ld_word_20_after", 1'b0, 2'd2, 32'h20, 32'h0, 32'h1122_3344, 1'b0);
        op("ld_misaligned_23", 1'b0, 2'd1, 32'h23, 32'h0, 32'h0, 1'b1);
`else
        op("st_misaligned_21", 1'b1, 2'd2, 32'h21, 32'hCAFE_F00D, 32'h0, 1'b0);
        op("ld_word_20_after", 1'b0, 2'd2, 32'h20, 32'h0, 32'hFEF0_0D44, 1'b0);
        op("ld_misaligned_23", 1'b0, 2'd1, 32'h23, 32'h0, 32'h0000_00FE, 1'b0);
`endif

        // Reset while a store is waiting: response dropped, store stays committed.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h30;
        req_wdata = 32'h0000_0055;
        step();
        req_valid = 1'b0;
        nReset = 1'b0;
        #1;
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_req_ready", {31'd0, req_ready}, 32'd0);
        step();
        nReset = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid === 1'b1) seen_valid = 1;
        end
        check("midreset_no_rsp", 32'(seen_valid), 32'd0);
        check("midreset_req_ready_after", {31'd0, req_ready}, 32'd1);
        op("ld_after_midreset", 1'b0, 2'd2, 32'h30, 32'h0, 32'h0000_0055, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
